// File: rtl/cache_pkg.sv
// Shared definitions for the cache-line / burst-memory adapter.
// Holds the line and beat geometry, the derived beat-counter width,
// the line/beat data types and the adapter state encoding.
package cache_pkg;

    localparam int LINE_W    = 256;
    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int OFFSET_W  = 5;
    localparam int CNT_W     = $clog2(BURST_LEN);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Converts 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Reads gather four beats into pmem_rdata and then pulse pmem_resp once.
// Writes latch the whole line when the request is accepted and send it
// out one beat at a time, lowest slice first.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   pmem_address    line request address from the cache
//   pmem_read/write line requests, held until pmem_resp
//   pmem_wdata      line to write
//   pmem_rdata      assembled read line (registered)
//   pmem_resp       one-cycle completion pulse
//   burst_address   line-aligned burst address
//   burst_read/write burst requests to memory
//   burst_wdata     current write beat
//   burst_rdata     returned read beat
//   burst_resp      beat accepted/valid this cycle
module cacheline_burst_adapter
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pmem_address,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  line_t       pmem_wdata,
    output line_t       pmem_rdata,
    output logic        pmem_resp,
    output logic [31:0] burst_address,
    output logic        burst_read,
    output logic        burst_write,
    output beat_t       burst_wdata,
    input  beat_t       burst_rdata,
    input  logic        burst_resp
);

    localparam logic [31:0] OFFSET_MASK = (32'd1 << OFFSET_W) - 32'd1;

    adapter_state_t state_q;
    adapter_state_t state_d;
    cnt_t           cnt_q;
    logic [31:0]    addr_q;
    line_t          wline_q;
    line_t          rdata_q;
    logic           last_beat;
    logic [31:0]    aligned_address;

    assign aligned_address = pmem_address & ~OFFSET_MASK;
    assign last_beat       = (cnt_q == cnt_t'(BURST_LEN - 1));

    // Next-state logic: write has priority over read when both are asked for.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    state_d = WR_BURST;
                end else if (pmem_read) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            WR_BURST: begin
                if (burst_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend on state only, so they drop asynchronously with reset.
    always_comb begin
        burst_read  = (state_q == RD_BURST);
        burst_write = (state_q == WR_BURST);
        pmem_resp   = (state_q == DONE);
        burst_wdata = '0;
        if (state_q == WR_BURST) begin
            burst_wdata = wline_q[int'(cnt_q)*BEAT_W +: BEAT_W];
        end
    end

    assign burst_address = addr_q;
    assign pmem_rdata    = rdata_q;

    // State, beat counter, latched request and the read assembly register.
    // The counter returns to 0 only via the last-beat transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (pmem_write) begin
                        addr_q  <= aligned_address;
                        wline_q <= pmem_wdata;
                    end else if (pmem_read) begin
                        addr_q <= aligned_address;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        rdata_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= burst_rdata;
                        cnt_q <= last_beat ? '0 : cnt_q + cnt_t'(1);
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        cnt_q <= last_beat ? '0 : cnt_q + cnt_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter.
// A transaction-level model follows the adapter cycle by cycle and is
// compared against every output on each falling edge; directed tests pin
// the model with literal values, then randomized traffic exercises it.
module tb_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    always #5 clk = ~clk;

    cacheline_burst_adapter dut (
        .clk           (clk),
        .rst           (rst_n),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    int tot = 0;
    int bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory responder: 0 = always respond, 1 = random, 2 = scripted for reads.
    int          rmode = 0;
    logic [63:0] beat_tab [4];
    logic [15:0] script_bits;
    int          sidx = 0;
    int          rb = 0;
    bit          acc_rd = 0;
    logic [63:0] wq [$];

    always @(negedge clk) begin
        if (acc_rd) rb++;
        if (!burst_read) rb = 0;
        case (rmode)
            0: burst_resp = 1'b1;
            1: burst_resp = ($urandom_range(0, 99) < 60);
            2: begin
                if (burst_read) begin
                    burst_resp = script_bits[sidx];
                    sidx++;
                end else begin
                    burst_resp = 1'b0;
                    sidx = 0;
                end
            end
            default: burst_resp = 1'b0;
        endcase
        burst_rdata = beat_tab[rb % 4];
        acc_rd = burst_read && burst_resp;
        if (burst_write && burst_resp) wq.push_back(burst_wdata);
    end

    // Behavioural model: what the adapter is doing in terms of transactions.
    bit           m_rd, m_wr, m_resp;
    int           m_beats;
    logic [31:0]  m_addr;
    logic [255:0] m_wline;
    logic [255:0] m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd = 0; m_wr = 0; m_resp = 0; m_beats = 0;
            m_addr = '0; m_wline = '0; m_rdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_rd) begin
            if (burst_resp) begin
                m_rdata[m_beats*64 +: 64] = burst_rdata;
                m_beats++;
                if (m_beats == 4) begin m_rd = 0; m_beats = 0; m_resp = 1; end
            end
        end else if (m_wr) begin
            if (burst_resp) begin
                m_beats++;
                if (m_beats == 4) begin m_wr = 0; m_beats = 0; m_resp = 1; end
            end
        end else if (pmem_write) begin
            m_addr  = pmem_address - (pmem_address % 32);
            m_wline = pmem_wdata;
            m_wr    = 1;
        end else if (pmem_read) begin
            m_addr = pmem_address - (pmem_address % 32);
            m_rd   = 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("burst_read", burst_read, m_rd);
        check("burst_write", burst_write, m_wr);
        check("pmem_resp", pmem_resp, m_resp);
        check("burst_address", burst_address, m_addr);
        check("pmem_rdata", pmem_rdata, m_rdata);
        check("burst_wdata", burst_wdata, m_wr ? m_wline[m_beats*64 +: 64] : 64'd0);
    end

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [255:0] wd, output int cyc);
        bit ok;
        wq.delete();
        @(negedge clk);
        pmem_address = a; pmem_read = rd; pmem_write = wr; pmem_wdata = wd;
        cyc = 1; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (wr) pmem_wdata = {8{$urandom}};
            if (pmem_resp) begin ok = 1; break; end
        end
        pmem_read = 0; pmem_write = 0;
        if (!ok) begin
            tot++; bad++;
            $display("[TB] FAIL resp_timeout: got none want pmem_resp");
        end
    endtask

    function automatic logic [255:0] tab_line();
        return {beat_tab[3], beat_tab[2], beat_tab[1], beat_tab[0]};
    endfunction

    task automatic checkOutput(input bit wr, input logic [255:0] wd);
        if (wr) begin
            check("wr_beat_count", wq.size(), 4);
            for (int i = 0; i < 4 && i < wq.size(); i++) check("wr_beat", wq[i], wd[i*64 +: 64]);
        end else begin
            check("rd_line", pmem_rdata, tab_line());
        end
    endtask

    task automatic both_req(input logic [31:0] a, input logic [255:0] wd);
        int pulses = 0;
        bit ok = 0;
        wq.delete();
        @(negedge clk);
        pmem_address = a; pmem_read = 1; pmem_write = 1; pmem_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pmem_resp) begin ok = 1; pulses++; break; end
        end
        pmem_write = 0;
        checkOutput(1, wd);
        check("both_first_no_read", burst_read, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pmem_resp) begin ok = ok && 1; pulses++; break; end
        end
        pmem_read = 0;
        checkOutput(0, wd);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (pmem_resp) pulses++;
        end
        check("both_pulses", pulses, 2);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got hang want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        logic [255:0] wd;
        rst_n = 0; pmem_address = 0; pmem_read = 0; pmem_write = 0; pmem_wdata = 0;
        burst_resp = 0; burst_rdata = 0; script_bits = 0;
        for (int i = 0; i < 4; i++) beat_tab[i] = 0;
        #1;
        check("rst_burst_read", burst_read, 0);
        check("rst_pmem_resp", pmem_resp, 0);
        check("rst_burst_address", burst_address, 0);
        check("rst_pmem_rdata", pmem_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Directed read, continuous responses
        rmode = 0;
        beat_tab[0] = {16{4'h1}}; beat_tab[1] = {16{4'h2}};
        beat_tab[2] = {16{4'h3}}; beat_tab[3] = {16{4'h4}};
        applyStimulus(1, 0, 32'h0000_1234, '0, cyc);
        check("rd_latency", cyc, 6);
        check("rd_addr", burst_address, 32'h0000_1220);
        check("rd_line_lit", pmem_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        // Directed write
        wd = {64'hD, 64'hC, 64'hB, 64'hA};
        applyStimulus(0, 1, 32'h8000_00FF, wd, cyc);
        check("wr_addr", burst_address, 32'h8000_00E0);
        check("wr_latency", cyc, 6);
        check("wr_beats_n", wq.size(), 4);
        if (wq.size() == 4) begin
            check("wr_beat_a", wq[0], 64'hA);
            check("wr_beat_b", wq[1], 64'hB);
            check("wr_beat_c", wq[2], 64'hC);
            check("wr_beat_d", wq[3], 64'hD);
        end

        // Read with a two-cycle stall after the second beat
        rmode = 2; script_bits = 16'b1111_1111_1111_0011;
        applyStimulus(1, 0, 32'h0000_1234, '0, cyc);
        check("stall_latency", cyc, 8);
        check("stall_line", pmem_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        rmode = 0;

        // Write-back then fill
        for (int i = 0; i < 4; i++) beat_tab[i] = {$urandom, $urandom};
        both_req(32'h0000_4040, {8{32'hCAFE_F00D}});

        // Spurious responses in idle must not start anything
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("spur_resp", pmem_resp, 0);
            check("spur_read", burst_read, 0);
        end
        applyStimulus(1, 0, 32'h0000_0100, '0, cyc);
        check("post_spur_latency", cyc, 6);
        checkOutput(0, '0);

        // Reset after two read beats
        beat_tab[0] = 64'h1111; beat_tab[1] = 64'h2222;
        beat_tab[2] = 64'h3333; beat_tab[3] = 64'h4444;
        @(negedge clk);
        pmem_address = 32'h0000_2000; pmem_read = 1;
        repeat (3) @(negedge clk);
        check("pre_rst_partial", pmem_rdata[127:0], {64'h2222, 64'h1111});
        #1 rst_n = 0; pmem_read = 0;
        #1;
        check("mid_rst_read", burst_read, 0);
        check("mid_rst_resp", pmem_resp, 0);
        check("mid_rst_rdata", pmem_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        applyStimulus(1, 0, 32'h0000_2008, '0, cyc);
        check("post_rst_latency", cyc, 6);
        check("post_rst_line", pmem_rdata, {64'h4444, 64'h3333, 64'h2222, 64'h1111});

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            rmode = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) beat_tab[i] = {$urandom, $urandom};
            wd = {8{$urandom}};
            if (kind == 3) begin
                both_req($urandom, wd);
            end else begin
                applyStimulus(kind != 2, kind == 2, $urandom, wd, cyc);
                checkOutput(kind == 2, wd);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
